// File: rtl/dma_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module      : dma_copy_engine
//  Description : AHB-lite register slave (SRC, DST, CTRL) driving a
//                single-channel word-copy engine over a req/ack memory port.
//                Completion is reported by a sticky done flag and a
//                one-cycle irq pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module dma_copy_engine #(
    parameter logic [31:0] SRC_ADDR  = 32'h40000010,
    parameter logic [31:0] DST_ADDR  = 32'h40000060,
    parameter logic [31:0] CTRL_ADDR = 32'h40000090,
    parameter int          LEN_W     = 16
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        irq
);

    localparam logic [1:0]       ST_IDLE = 2'd0;
    localparam logic [1:0]       ST_RD   = 2'd1;
    localparam logic [1:0]       ST_WR   = 2'd2;
    localparam logic [1:0]       ST_DONE = 2'd3;
    localparam logic [LEN_W-1:0] C_ONE   = LEN_W'(1);

    logic [1:0]       state_q,     state_d;
    logic [31:0]      addr_q,      addr_d;
    logic             write_q,     write_d;
    logic             valid_q,     valid_d;
    logic [31:0]      src_q,       src_d;
    logic [31:0]      dst_q,       dst_d;
    logic [31:0]      buf_q,       buf_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             irq_q,       irq_d;

    logic             w_wr_ok;
    logic             w_wr_src;
    logic             w_wr_dst;
    logic             w_wr_ctrl;
    logic             w_start;
    logic             w_clr;
    logic [LEN_W-1:0] w_len;
    logic             w_rd_ack;
    logic             w_wr_ack;
    logic             w_unused;

    // Inputs that carry no information for this slave
    assign w_unused = ^{hsize, htrans[0], hwdata[29:LEN_W]};

    // Zero-wait-state slave that never signals an error
    assign hreadyout = 1'b1;
    assign hresp     = 1'b0;

    // Data-phase write decode; register writes are locked out while a copy runs
    always_comb begin
        w_wr_ok   = valid_q && write_q && !busy_q;
        w_wr_src  = w_wr_ok && (addr_q == SRC_ADDR);
        w_wr_dst  = w_wr_ok && (addr_q == DST_ADDR);
        w_wr_ctrl = w_wr_ok && (addr_q == CTRL_ADDR);
        w_start   = w_wr_ctrl && hwdata[31];
        w_clr     = w_wr_ctrl && hwdata[30];
        w_len     = hwdata[LEN_W-1:0];
        w_rd_ack  = (state_q == ST_RD) && mem_ack;
        w_wr_ack  = (state_q == ST_WR) && mem_ack;
    end

    // Read mux, only meaningful during a read data phase
    always_comb begin
        hrdata = 32'h0;
        if (valid_q && !write_q) begin
            if (addr_q == SRC_ADDR) begin
                hrdata = src_q;
            end else if (addr_q == DST_ADDR) begin
                hrdata = dst_q;
            end else if (addr_q == CTRL_ADDR) begin
                hrdata = {busy_q, done_q, {(30-LEN_W){1'b0}}, remaining_q};
            end
        end
    end

    // Copy FSM state register
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Copy FSM next-state: alternate read/write per word, one-cycle DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    state_d = (w_len != '0) ? ST_RD : ST_DONE;
                end
            end
            ST_RD: begin
                if (mem_ack) begin
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (mem_ack) begin
                    state_d = (remaining_q <= C_ONE) ? ST_DONE : ST_RD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Copy FSM outputs: memory request held steady for the whole state
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        irq       = irq_q;
        case (state_q)
            ST_RD: begin
                mem_req  = 1'b1;
                mem_addr = src_q;
            end
            ST_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = dst_q;
                mem_wdata = buf_q;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    // Next values for the AHB pipeline, registers and copy datapath
    always_comb begin
        addr_d      = addr_q;
        write_d     = write_q;
        valid_d     = hready && htrans[1];
        src_d       = src_q;
        dst_d       = dst_q;
        buf_d       = buf_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        done_d      = done_q;
        irq_d       = (state_q == ST_DONE);

        if (valid_d) begin
            addr_d  = haddr;
            write_d = hwrite;
        end

        if (w_wr_src) begin
            src_d = {hwdata[31:2], 2'b00};
        end
        if (w_wr_dst) begin
            dst_d = {hwdata[31:2], 2'b00};
        end
        if (w_start) begin
            remaining_d = w_len;
            busy_d      = 1'b1;
            done_d      = 1'b0;
        end else if (w_clr) begin
            done_d = 1'b0;
        end

        if (w_rd_ack) begin
            buf_d = mem_rdata;
        end
        if (w_wr_ack) begin
            src_d = src_q + 32'd4;
            dst_d = dst_q + 32'd4;
            if (remaining_q != '0) begin
                remaining_d = remaining_q - C_ONE;
            end
        end

        if (state_q == ST_DONE) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
    end

    // Register the AHB pipeline, registers and copy datapath
    always_ff @(posedge hclk) begin
        if (hreset) begin
            addr_q      <= 32'h0;
            write_q     <= 1'b0;
            valid_q     <= 1'b0;
            src_q       <= 32'h0;
            dst_q       <= 32'h0;
            buf_q       <= 32'h0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            write_q     <= write_d;
            valid_q     <= valid_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            buf_q       <= buf_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            irq_q       <= irq_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_copy_engine
//  Description : Directed bench for dma_copy_engine. A memory responder with
//                programmable ack latency checks every memory request against
//                an expected-transaction queue, and irq on every cycle against
//                the predicted completion cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dma_copy_engine;

    localparam logic [31:0] C_SRC  = 32'h40000010;
    localparam logic [31:0] C_DST  = 32'h40000060;
    localparam logic [31:0] C_CTRL = 32'h40000090;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic [31:0] haddr = 32'h0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b010;
    logic [31:0] hwdata = 32'h0;
    logic        hready = 1'b1;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        irq;

    dma_copy_engine dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hready    (hready),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .irq       (irq)
    );

    always #5 hclk = ~hclk;

    int cyc = 0;
    always @(posedge hclk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] act_log[$];
    int errors = 0;
    int checks = 0;
    int ack_lat = 0;
    int exp_irq_cyc = -1;
    int first_req_cyc = -1;
    int last_irq_cyc = -1;
    int irq_count = 0;

    // Responder-side state
    bit          pend = 1'b0;
    int          wait_cnt = 0;
    logic        h_we = 1'b0;
    logic [31:0] h_addr = 32'h0;
    logic [31:0] h_wdata = 32'h0;
    txn_t        e;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge hclk); #1;
        haddr = a; htrans = 2'b10; hwrite = 1'b1;
        @(posedge hclk); #1;
        haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0; hwdata = d;
    endtask

    // Two writes with the second address phase overlapping the first data phase
    task automatic ahb_write_b2b(input logic [31:0] a1, input logic [31:0] d1,
                                 input logic [31:0] a2, input logic [31:0] d2);
        @(posedge hclk); #1;
        haddr = a1; htrans = 2'b10; hwrite = 1'b1;
        @(posedge hclk); #1;
        haddr = a2; hwdata = d1;
        @(posedge hclk); #1;
        haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0; hwdata = d2;
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        @(posedge hclk); #1;
        haddr = a; htrans = 2'b10; hwrite = 1'b0;
        @(posedge hclk); #1;
        haddr = 32'h0; htrans = 2'b00;
        @(negedge hclk);
        d = hrdata;
    endtask

    // Program and launch a copy; queue the exact memory traffic it must produce
    task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input int len,
                              input int lat, output int dcyc);
        txn_t t;
        ack_lat = lat;
        ahb_write_b2b(C_SRC, s, C_DST, d);
        ahb_write(C_CTRL, 32'h80000000 | 32'(len));
        dcyc = cyc;
        act_log.delete();
        first_req_cyc = -1;
        irq_count = 0;
        for (int i = 0; i < len; i++) begin
            t.we = 1'b0; t.addr = s + 32'(4*i); t.data = 32'h0;
            exp_q.push_back(t);
            t.we = 1'b1; t.addr = d + 32'(4*i); t.data = mem_fn(s + 32'(4*i));
            exp_q.push_back(t);
        end
        // Each of 2*len requests occupies lat+1 cycles, first one right after
        // the data phase; irq follows the single DONE cycle.
        exp_irq_cyc = (len == 0) ? dcyc + 2 : dcyc + 2 + 2*len*(lat+1);
    endtask

    task automatic wait_copy();
        repeat (exp_irq_cyc - cyc + 2) @(posedge hclk);
        #1;
        check("txn_queue_empty", 32'(exp_q.size()), 32'd0);
        check("irq_count", 32'(irq_count), 32'd1);
    endtask

    // Memory responder and per-cycle output comparison
    initial begin : p_compare
        forever begin
            @(negedge hclk);
            mem_ack = 1'b0;
            if (hreset) begin
                pend = 1'b0;
            end else begin
                check("hreadyout", 32'(hreadyout), 32'd1);
                check("hresp", 32'(hresp), 32'd0);
                check("irq", 32'(irq), (cyc == exp_irq_cyc) ? 32'd1 : 32'd0);
                if (irq === 1'b1) begin
                    irq_count++;
                    last_irq_cyc = cyc;
                end
                if (mem_req === 1'b1) begin
                    if (!pend) begin
                        if (first_req_cyc < 0) first_req_cyc = cyc;
                        act_log.push_back(mem_addr);
                        if (exp_q.size() == 0) begin
                            check("unexpected_mem_req", mem_addr, 32'hFFFFFFFF);
                        end else begin
                            e = exp_q.pop_front();
                            check("mem_we", 32'(mem_we), 32'(e.we));
                            check("mem_addr", mem_addr, e.addr);
                            if (e.we) check("mem_wdata", mem_wdata, e.data);
                        end
                        pend = 1'b1;
                        wait_cnt = 0;
                        h_we = mem_we; h_addr = mem_addr; h_wdata = mem_wdata;
                    end else begin
                        check("stable_we", 32'(mem_we), 32'(h_we));
                        check("stable_addr", mem_addr, h_addr);
                        check("stable_wdata", mem_wdata, h_wdata);
                    end
                    if (wait_cnt >= ack_lat) begin
                        mem_ack = 1'b1;
                        mem_rdata = mem_we ? 32'h0 : mem_fn(mem_addr);
                        pend = 1'b0;
                    end else begin
                        wait_cnt++;
                    end
                end
            end
        end
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        logic [31:0] rd;
        int dcyc;

        // Reset state
        repeat (2) @(posedge hclk);
        #1 hreset = 1'b0;
        @(negedge hclk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_hrdata", hrdata, 32'h0);
        ahb_read(C_CTRL, rd); check("rst_ctrl", rd, 32'h0);
        ahb_read(C_SRC, rd);  check("rst_src", rd, 32'h0);

        // Register read/write with low-bit masking and an unmapped read
        ahb_write(C_SRC, 32'h00001003);
        ahb_write(C_DST, 32'h00002000);
        ahb_read(C_SRC, rd);        check("reg_src", rd, 32'h00001000);
        ahb_read(C_DST, rd);        check("reg_dst", rd, 32'h00002000);
        ahb_read(32'h40000020, rd); check("reg_unmapped", rd, 32'h0);

        // Three-word copy with zero-latency memory
        start_copy(32'h00001000, 32'h00002000, 3, 0, dcyc);
        wait_copy();
        check("copy3_first_req", 32'(first_req_cyc), 32'(dcyc + 1));
        check("copy3_irq_delay", 32'(last_irq_cyc - first_req_cyc), 32'd7);
        check("copy3_nlog", 32'(act_log.size()), 32'd6);
        if (act_log.size() == 6) begin
            check("copy3_a0", act_log[0], 32'h00001000);
            check("copy3_a1", act_log[1], 32'h00002000);
            check("copy3_a2", act_log[2], 32'h00001004);
            check("copy3_a3", act_log[3], 32'h00002004);
            check("copy3_a4", act_log[4], 32'h00001008);
            check("copy3_a5", act_log[5], 32'h00002008);
        end
        ahb_read(C_CTRL, rd); check("copy3_ctrl", rd, 32'h40000000);
        ahb_read(C_SRC, rd);  check("copy3_src", rd, 32'h0000100C);
        ahb_read(C_DST, rd);  check("copy3_dst", rd, 32'h0000200C);

        // Slow memory: ack three cycles after the request appears
        start_copy(32'h00003000, 32'h00004000, 2, 3, dcyc);
        wait_copy();
        check("slow_irq_cycle", 32'(last_irq_cyc), 32'(dcyc + 18));

        // Busy lockout
        start_copy(32'h00005000, 32'h00006000, 4, 1, dcyc);
        ahb_write(C_SRC, 32'hDEAD0000);
        ahb_write(C_CTRL, 32'h80000009);
        ahb_read(C_CTRL, rd); check("lock_busy", 32'(rd[31]), 32'd1);
        wait_copy();
        ahb_read(C_SRC, rd);  check("lock_src", rd, 32'h00005010);
        ahb_read(C_CTRL, rd); check("lock_ctrl", rd, 32'h40000000);

        // CLR_DONE
        ahb_write(C_CTRL, 32'h40000000);
        ahb_read(C_CTRL, rd); check("clr_done", rd, 32'h0);

        // START with LEN=0: irq only, no memory traffic
        ack_lat = 0;
        ahb_write(C_CTRL, 32'h80000000);
        dcyc = cyc;
        first_req_cyc = -1; irq_count = 0;
        exp_irq_cyc = dcyc + 2;
        wait_copy();
        check("len0_irq_cycle", 32'(last_irq_cyc), 32'(dcyc + 2));
        check("len0_no_req", 32'(first_req_cyc), 32'hFFFFFFFF);
        ahb_read(C_CTRL, rd); check("len0_ctrl", rd, 32'h40000000);

        // Source address wrap
        start_copy(32'hFFFFFFFC, 32'h00007000, 2, 0, dcyc);
        wait_copy();
        check("wrap_nlog", 32'(act_log.size()), 32'd4);
        if (act_log.size() == 4) check("wrap_second_read", act_log[2], 32'h00000000);
        ahb_read(C_SRC, rd); check("wrap_src", rd, 32'h00000004);

        // Reset in the middle of a copy
        start_copy(32'h00008000, 32'h00009000, 8, 0, dcyc);
        ahb_read(C_CTRL, rd); check("mid_ctrl", rd, 32'h80000008);
        repeat (5) @(posedge hclk);
        #1;
        hreset = 1'b1;
        exp_q.delete();
        exp_irq_cyc = -1;
        repeat (2) @(posedge hclk);
        #1 hreset = 1'b0;
        @(negedge hclk);
        check("abort_mem_req", 32'(mem_req), 32'd0);
        check("abort_irq", 32'(irq), 32'd0);
        ahb_read(C_CTRL, rd); check("abort_ctrl", rd, 32'h0);
        ahb_read(C_SRC, rd);  check("abort_src", rd, 32'h0);
        repeat (20) @(posedge hclk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
